render_rect_stream: RTL

- Parametrised successor to the rectangle renderer: rasterises one rectangle per start pulse into a pixel stream (x, y, color, plot) for the VGA framebuffer writer.
- Adds configurable border thickness and outline-only mode.
- Adds on-screen clipping (off-screen pixels never plotted), a ready back-pressure handshake, abort, and busy/done status.
- Scans with nested x/y counters; no divide or modulo hardware.

---
 rtl/render_pkg.sv | 24 ++
 rtl/rect_scan_counter.sv | 47 ++++
 rtl/render_rect_stream.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared definitions for the render_* block family: screen defaults, field widths, modes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package render_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int X_W_DEF      = 9;
  localparam int Y_W_DEF      = 8;
  localparam int COLOR_W_DEF  = 3;
  localparam int BW_W_DEF     = 4;

  // Draw modes; encoding 3 is reserved and falls through to plain fill.
  localparam logic [1:0] MODE_FILL        = 2'd0;
  localparam logic [1:0] MODE_FILL_BORDER = 2'd1;
  localparam logic [1:0] MODE_OUTLINE     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } render_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster-order 2-D counter: cx runs 0..width-1, then wraps and bumps cy; last flags the final cell.
// Latency: counts update one cycle after advance; last is combinational from the counters.
// Backpressure: holds its position whenever advance is low.
module rect_scan_counter
  import render_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           advance,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  logic row_end;

  // End-of-row / end-of-rect detection, widened so width-1 never wraps.
  always_comb begin
    row_end = ({1'b0, cx} == ({1'b0, width} - {{X_W{1'b0}}, 1'b1}));
    last    = row_end && ({1'b0, cy} == ({1'b0, height} - {{Y_W{1'b0}}, 1'b1}));
  end

  // Counter register: clear wins over advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (row_end) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/render_rect_stream.sv
// Rasterises one rectangle per start into a clipped pixel stream (fill, fill+border, outline).
// Latency: first candidate the cycle after start; done after width*height candidate cycles plus stalls.
// Backpressure: a plotted pixel is held stable until ready; skipped pixels cost one cycle each.
module render_rect_stream
  import render_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int BW_W     = BW_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] back_color,
  input  logic [COLOR_W-1:0] border_color,
  input  logic [BW_W-1:0]    border_w,
  input  logic [1:0]         mode,
  input  logic               ready,
  output logic [X_W-1:0]     x_stream,
  output logic [Y_W-1:0]     y_stream,
  output logic [COLOR_W-1:0] color_stream,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  render_state_t state_q, state_d;

  logic [X_W-1:0]     ox_q, w_q;
  logic [Y_W-1:0]     oy_q, h_q;
  logic [COLOR_W-1:0] back_q, bord_q;
  logic [BW_W-1:0]    bw_q;
  logic [1:0]         mode_q;

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           last;
  logic           clear, advance;

  logic [X_W:0]       ax, bw_x;
  logic [Y_W:0]       ay, bw_y;
  logic               in_border, skip;
  logic [COLOR_W-1:0] pix_color;

  rect_scan_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .advance (advance),
    .width   (w_q),
    .height  (h_q),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  // Snapshot the rectangle attributes when a start is accepted so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox_q   <= '0;
      oy_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      back_q <= '0;
      bord_q <= '0;
      bw_q   <= '0;
      mode_q <= MODE_FILL;
    end else if (state_q == ST_IDLE && start) begin
      ox_q   <= origin_x;
      oy_q   <= origin_y;
      w_q    <= width;
      h_q    <= height;
      back_q <= back_color;
      bord_q <= border_color;
      bw_q   <= border_w;
      mode_q <= mode;
    end
  end

  // Candidate pixel datapath: absolute position, border membership, clipping and colour.
  always_comb begin
    ax   = {1'b0, ox_q} + {1'b0, cx};
    ay   = {1'b0, oy_q} + {1'b0, cy};
    bw_x = (X_W+1)'(bw_q);
    bw_y = (Y_W+1)'(bw_q);
    // cx + bw >= width is the overflow-free form of cx >= width - bw.
    in_border = (bw_q != '0) &&
                (({1'b0, cx} < bw_x) || (({1'b0, cx} + bw_x) >= {1'b0, w_q}) ||
                 ({1'b0, cy} < bw_y) || (({1'b0, cy} + bw_y) >= {1'b0, h_q}));
    skip = (ax >= X_LIM) || (ay >= Y_LIM) || ((mode_q == MODE_OUTLINE) && !in_border);
    case (mode_q)
      MODE_FILL_BORDER: pix_color = in_border ? bord_q : back_q;
      MODE_OUTLINE:     pix_color = bord_q;
      default:          pix_color = back_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stream outputs; abort outranks advancing the scan.
  always_comb begin
    state_d      = state_q;
    clear        = 1'b0;
    advance      = 1'b0;
    plot         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    x_stream     = '0;
    y_stream     = '0;
    color_stream = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = (width == '0 || height == '0) ? ST_DONE : ST_DRAW;
        end
      end
      ST_DRAW: begin
        busy = 1'b1;
        plot = !skip;
        if (!skip) begin
          x_stream     = ax[X_W-1:0];
          y_stream     = ay[Y_W-1:0];
          color_stream = pix_color;
        end
        if (abort) begin
          state_d = ST_IDLE;
        end else if (skip || ready) begin
          advance = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
